// File: rtl/rldramii_st_pkg.sv
// Shared constants and helpers for the RLDRAMII DMA-master status stream adapter.
package rldramii_st_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    if (value > 1) begin
      for (int unsigned x = value - 1; x > 0; x = x >> 1) bits++;
    end
    return bits;
  endfunction

  localparam int unsigned PTR_W = clog2(DEF_DEPTH);
  localparam int unsigned LVL_W = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/rldramii_st_fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module rldramii_st_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rldramii_dmaster_st_buffer_adt.sv
// Avalon-ST timing adapter: buffers a non-stallable source against a backpressuring sink,
// reporting dropped beats through a sticky flag and a saturating counter.
module rldramii_dmaster_st_buffer_adt
  import rldramii_st_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [clog2(DEPTH+1)-1:0]     level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count,
  input  logic                          clr_overflow
);

  localparam int unsigned PTR_BITS = clog2(DEPTH);
  localparam int unsigned LVL_BITS = clog2(DEPTH + 1);
  localparam logic [LVL_BITS-1:0] LVL_FULL = LVL_BITS'(DEPTH);

  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  assign out_valid = (level != '0);
  assign full      = (level == LVL_FULL);
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same edge, so a full FIFO still accepts the beat.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  rldramii_st_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_BITS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop coincident with a clear wins: the clear restarts counting from this drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (!(&drop_count)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rldramii_dmaster_st_buffer_adt.sv
// Directed-vector bench for the status stream buffer adapter (DEPTH=4, CNT_W=2).
module tb_rldramii_dmaster_st_buffer_adt;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic [1:0] drop_count;
  logic       clr_overflow;

  int vectors = 0;
  int errors  = 0;

  rldramii_dmaster_st_buffer_adt #(
    .DATA_W (8),
    .DEPTH  (4),
    .CNT_W  (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    vectors++; if (drop_count !== 2'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_count); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL pass_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(i)); end
      vectors++; if (level !== 3'd1) begin errors++; $display("FAIL pass_level[%0d] got %0d want 1", i, level); end
    end
    in_valid = 1'b0;
    step();
    vectors++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pass_empty got lvl=%0d v=%b want 0/0", level, out_valid); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL pass_overflow got %b want 0", overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_q [4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = exp_q[i];
      step();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
    vectors++; if (out_data !== 8'h11) begin errors++; $display("FAIL fill_head got %h want 11", out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin errors++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_q[k]); end
      step();
      vectors++; if (level !== 3'(3 - k)) begin errors++; $display("FAIL drain_level[%0d] got %0d want %0d", k, level, 3 - k); end
    end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    vectors++; if (drop_count !== 2'd2) begin errors++; $display("FAIL ovf_count got %0d want 2", drop_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'hA0 + 8'(k)); end
      step();
    end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", out_valid); end
    out_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    vectors++; if (overflow !== 1'b0 || drop_count !== 2'd0) begin errors++; $display("FAIL ovf_clear got o=%b c=%0d want 0/0", overflow, drop_count); end
  endtask

  task automatic test_back_to_back_full();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hB4;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++; if (level !== 3'd4) begin errors++; $display("FAIL full_pp_level got %0d want 4", level); end
    vectors++; if (drop_count !== 2'd0 || overflow !== 1'b0) begin errors++; $display("FAIL full_pp_drop got o=%b c=%0d want 0/0", overflow, drop_count); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'hB0 + 8'(k)) begin errors++; $display("FAIL full_pp_drain[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'hB0 + 8'(k)); end
      step();
    end
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL full_pp_empty got %0d want 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(i);
      step();
    end
    vectors++; if (drop_count !== 2'd3 || overflow !== 1'b1) begin errors++; $display("FAIL sat_count got o=%b c=%0d want 1/3", overflow, drop_count); end
    step();
    vectors++; if (drop_count !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", drop_count); end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0; in_valid = 1'b0;
    vectors++; if (overflow !== 1'b1 || drop_count !== 2'd1) begin errors++; $display("FAIL clr_race got o=%b c=%0d want 1/1", overflow, drop_count); end
    vectors++; if (out_data !== 8'hD0) begin errors++; $display("FAIL sat_head got %h want d0", out_data); end
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL sat_drained got %0d want 0", level); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL areset_pre got lvl=%0d o=%b want 3/1", level, overflow); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL areset_fifo got v=%b lvl=%0d want 0/0", out_valid, level); end
    vectors++; if (overflow !== 1'b0 || drop_count !== 2'd0) begin errors++; $display("FAIL areset_ovf got o=%b c=%0d want 0/0", overflow, drop_count); end
    step();
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'hC5;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'hC5 || level !== 3'd1) begin errors++; $display("FAIL areset_first got v=%b d=%h lvl=%0d want 1/c5/1", out_valid, out_data, level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++; if (level !== 3'd0) begin errors++; $display("FAIL areset_pop got %0d want 0", level); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fill_drain();
    test_overflow();
    test_back_to_back_full();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
